wb_regfile: RTL and testbench

Write-back stage and general-purpose register file for the five-stage pipeline CPU. It consumes the MEM/WB pipeline outputs and selects the write-back value: loaded memory word or ALU result. It commits that value into a 32 × 32-bit register file and serves the two combinational read ports used by the ID stage. A write-through bypass forwards the same-cycle write to the read ports, and a counter tracks committed register writes.

---
 rtl/wb_regfile.sv | 68 ++++++
 tb/tb_wb_regfile.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back select plus 32x32 register file with r0 hardwired to zero,
// write-through bypass on both combinational read ports, and a commit counter.
module wb_regfile #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      wb_Alu_Result,
    input  logic [31:0]      wb_mo,
    input  logic             wb_m2reg,
    input  logic             wb_wreg,
    input  logic [4:0]       wb_rn,
    input  logic [4:0]       rna,
    input  logic [4:0]       rnb,
    output logic [31:0]      qa,
    output logic [31:0]      qb,
    output logic [31:0]      wb_data,
    output logic [CNT_W-1:0] wr_cnt
);

    logic [31:0]      regs_q [32];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             commit_s;

    // Write-back select, commit qualification and counter next state.
    always_comb begin
        wb_data  = wb_m2reg ? wb_mo : wb_Alu_Result;
        commit_s = (!clr) && wb_wreg && (wb_rn != 5'd0);
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Read ports: r0 is zero, then the same-cycle write wins, then the array.
    always_comb begin
        if (rna == 5'd0) begin
            qa = 32'd0;
        end else if (commit_s && (wb_rn == rna)) begin
            qa = wb_data;
        end else begin
            qa = regs_q[rna];
        end
        if (rnb == 5'd0) begin
            qb = 32'd0;
        end else if (commit_s && (wb_rn == rnb)) begin
            qb = wb_data;
        end else begin
            qb = regs_q[rnb];
        end
    end

    // Register array and commit counter; clr clears both immediately.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            cnt_q <= {CNT_W{1'b0}};
        end else if (commit_s) begin
            regs_q[wb_rn] <= wb_data;
            cnt_q         <= cnt_d;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed-vector bench for wb_regfile; stimulus queues expected values and a
// monitor process compares them against the DUT outputs at each sample strobe.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] wb_Alu_Result;
    logic [31:0] wb_mo;
    logic        wb_m2reg;
    logic        wb_wreg;
    logic [4:0]  wb_rn;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa, qb, wb_data, wr_cnt;
    logic [31:0] qa4, qb4, wb_data4;
    logic [3:0]  wr_cnt4;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    event ev_sample;
    int   checks = 0;
    int   errors = 0;

    localparam int K_QA = 0, K_QB = 1, K_CNT = 2, K_WBD = 3, K_CNT4 = 4, K_QA4 = 5;

    wb_regfile dut (
        .clk(clk), .clr(clr), .wb_Alu_Result(wb_Alu_Result), .wb_mo(wb_mo),
        .wb_m2reg(wb_m2reg), .wb_wreg(wb_wreg), .wb_rn(wb_rn), .rna(rna), .rnb(rnb),
        .qa(qa), .qb(qb), .wb_data(wb_data), .wr_cnt(wr_cnt)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clk(clk), .clr(clr), .wb_Alu_Result(wb_Alu_Result), .wb_mo(wb_mo),
        .wb_m2reg(wb_m2reg), .wb_wreg(wb_wreg), .wb_rn(wb_rn), .rna(rna), .rnb(rnb),
        .qa(qa4), .qb(qb4), .wb_data(wb_data4), .wr_cnt(wr_cnt4)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string n, input int k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic sample();
        -> ev_sample;
        #1;
    endtask

    task automatic drive(input logic wreg, input logic [4:0] rn, input logic [31:0] alu,
                         input logic [31:0] mo, input logic m2r,
                         input logic [4:0] ra, input logic [4:0] rb);
        wb_wreg = wreg; wb_rn = rn; wb_Alu_Result = alu; wb_mo = mo;
        wb_m2reg = m2r; rna = ra; rnb = rb;
        #1;
    endtask

    // Monitor: drain every queued expectation against the live DUT outputs.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(ev_sample);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.kind)
                    K_QA:    act = qa;
                    K_QB:    act = qb;
                    K_CNT:   act = wr_cnt;
                    K_WBD:   act = wb_data;
                    K_CNT4:  act = {28'd0, wr_cnt4};
                    K_QA4:   act = qa4;
                    default: act = 32'hxxxx_xxxx;
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s got %h want %h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        clr = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);

        // Reset: every register reads zero on both ports, counters zero.
        for (int r = 1; r < 32; r++) begin
            drive(1'b1, 5'(r), 32'hFFFF_FFFF, 32'd0, 1'b0, 5'(r), 5'(32 - r));
            expect_val($sformatf("rst_qa_r%0d", r), K_QA, 32'd0);
            expect_val($sformatf("rst_qb_r%0d", r), K_QB, 32'd0);
            sample();
        end
        drive(1'b0, 5'd0, 32'h0000_00A5, 32'h0000_005A, 1'b0, 5'd0, 5'd0);
        expect_val("rst_wbdata_alu", K_WBD, 32'h0000_00A5);
        expect_val("rst_cnt", K_CNT, 32'd0);
        expect_val("rst_cnt4", K_CNT4, 32'd0);
        sample();
        drive(1'b0, 5'd0, 32'h0000_00A5, 32'h0000_005A, 1'b1, 5'd0, 5'd0);
        expect_val("rst_wbdata_mem", K_WBD, 32'h0000_005A);
        sample();

        @(negedge clk);
        clr = 1'b0;

        // ALU then load write-back.
        drive(1'b1, 5'd5, 32'h1234_5678, 32'h0BAD_F00D, 1'b0, 5'd0, 5'd0);
        expect_val("alu_wbdata", K_WBD, 32'h1234_5678);
        sample();
        @(negedge clk);
        drive(1'b1, 5'd6, 32'h0000_0001, 32'hDEAD_BEEF, 1'b1, 5'd0, 5'd0);
        expect_val("load_wbdata", K_WBD, 32'hDEAD_BEEF);
        sample();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd5, 5'd6);
        expect_val("alu_r5", K_QA, 32'h1234_5678);
        expect_val("load_r6", K_QB, 32'hDEAD_BEEF);
        expect_val("cnt_after2", K_CNT, 32'd2);
        sample();

        // r0 protection.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0, 5'd0);
        expect_val("r0_pre_qa", K_QA, 32'd0);
        expect_val("r0_pre_qb", K_QB, 32'd0);
        sample();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0, 5'd0);
        expect_val("r0_post_qa", K_QA, 32'd0);
        expect_val("r0_post_cnt", K_CNT, 32'd2);
        sample();

        // Bypass: preload r7, then same-cycle write/read.
        drive(1'b1, 5'd7, 32'h0000_0011, 32'd0, 1'b0, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h0000_0022, 32'd0, 1'b0, 5'd7, 5'd7);
        expect_val("byp_qa", K_QA, 32'h0000_0022);
        expect_val("byp_qb", K_QB, 32'h0000_0022);
        sample();
        drive(1'b0, 5'd7, 32'h0000_0022, 32'd0, 1'b0, 5'd7, 5'd7);
        expect_val("nobyp_qa", K_QA, 32'h0000_0011);
        expect_val("nobyp_qb", K_QB, 32'h0000_0011);
        sample();
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h0000_0033, 32'd0, 1'b0, 5'd7, 5'd5);
        expect_val("mix_qa_byp", K_QA, 32'h0000_0033);
        expect_val("mix_qb_reg", K_QB, 32'h1234_5678);
        expect_val("nobyp_cnt", K_CNT, 32'd3);
        sample();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd7, 5'd5);
        expect_val("r7_kept", K_QA, 32'h0000_0011);
        sample();

        // Asynchronous clear mid-cycle, with a commit attempt during clr.
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h0000_0099, 32'd0, 1'b0, 5'd5, 5'd9);
        expect_val("pre_clr_qa", K_QA, 32'h1234_5678);
        expect_val("pre_clr_qb_byp", K_QB, 32'h0000_0099);
        sample();
        clr = 1'b1;
        #1;
        expect_val("async_clr_qa", K_QA, 32'd0);
        expect_val("async_clr_qb", K_QB, 32'd0);
        expect_val("async_clr_cnt", K_CNT, 32'd0);
        expect_val("async_clr_cnt4", K_CNT4, 32'd0);
        sample();
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h0000_0099, 32'd0, 1'b0, 5'd9, 5'd9);
        expect_val("lost_commit_qa", K_QA, 32'd0);
        expect_val("lost_commit_cnt", K_CNT, 32'd0);
        sample();
        clr = 1'b0;
        #1;
        expect_val("post_clr_byp", K_QA, 32'h0000_0099);
        sample();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd9, 5'd9);
        expect_val("first_edge_commit", K_QA, 32'h0000_0099);
        expect_val("first_edge_cnt", K_CNT, 32'd1);
        sample();

        // Counter wrap on the 4-bit instance: 17 commits to r3.
        clr = 1'b1;
        #1;
        clr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'd3, 32'(i + 1), 32'd0, 1'b0, 5'd3, 5'd0);
            @(negedge clk);
            drive(1'b0, 5'd3, 32'd0, 32'd0, 1'b0, 5'd3, 5'd0);
            expect_val($sformatf("wrap_cnt4_%0d", i + 1), K_CNT4, 32'((i + 1) % 16));
            sample();
        end
        expect_val("wrap_r3", K_QA4, 32'd17);
        expect_val("wrap_cnt32", K_CNT, 32'd17);
        sample();

        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
